n64_region_decoder: RTL and testbench

N64_REGION_DECODER -- requirements
Module: n64_region_decoder

---
 rtl/n64_region_decoder.sv | 192 +++++++++++++++++++
 tb/tb_n64_region_decoder.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/n64_region_decoder.sv
// N64 PI address region decoder: latches the PI address, matches it against
// programmable regions and tracks the word address across data transfers.
// Optional write protection is enabled with N64_REGION_DECODER_WRITE_PROTECT_EN.
module n64_region_decoder #(
   parameter int                NUM_REGIONS  = 8,
   parameter int                BANK_W       = 4,
   parameter logic [BANK_W-1:0] BANK_INVALID = '0
) (
   input  logic                        i_clk,
   input  logic                        i_reset_n,
   input  logic                        i_address_high_op,
   input  logic                        i_address_low_op,
   input  logic [15:0]                 i_n64_pi_ad,
   input  logic                        i_access_op,
   input  logic                        i_write,
   input  logic [NUM_REGIONS-1:0]      i_region_enable,
   input  logic [16*NUM_REGIONS-1:0]   i_region_base,
   input  logic [16*NUM_REGIONS-1:0]   i_region_mask,
   input  logic [BANK_W*NUM_REGIONS-1:0] i_region_bank,
   input  logic [NUM_REGIONS-1:0]      i_region_prefetch,
   input  logic [NUM_REGIONS-1:0]      i_region_wp,
   output logic [BANK_W-1:0]           o_bank,
   output logic                        o_prefetch,
   output logic                        o_valid,
   output logic [31:0]                 o_address,
   output logic                        o_crossing,
   output logic                        o_write_blocked
);

   localparam int IDX_W = (NUM_REGIONS > 1) ? $clog2(NUM_REGIONS) : 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_HIGH   = 2'd1,
      ST_ACTIVE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [31:0]         addr_q, addr_d;
   logic                m_hit_q, m_hit_d;
   logic [15:0]         m_base_q, m_base_d;
   logic [15:0]         m_mask_q, m_mask_d;
   logic [BANK_W-1:0]   m_bank_q, m_bank_d;
   logic                m_pref_q, m_pref_d;
   logic                m_wp_q, m_wp_d;
   logic                crossed_q, crossed_d;
   logic [BANK_W-1:0]   bank_q, bank_d;
   logic                pref_q, pref_d;
   logic                valid_q, valid_d;
   logic                cross_q, cross_d;
   logic                wb_q, wb_d;

   logic                sel_hit_s;
   logic [IDX_W-1:0]    sel_idx_s;
   logic [15:0]         sel_mask_s;
   logic [31:0]         incr_s;
   logic                leaves_s;
   logic                blocked_s;
   logic                unused_s;

   // Priority select: scan downward so the lowest-index enabled match wins.
   always_comb begin
      sel_hit_s = 1'b0;
      sel_idx_s = '0;
      for (int r = NUM_REGIONS - 1; r >= 0; r--) begin
         if (i_region_enable[r] &&
             ((i_n64_pi_ad & i_region_mask[16*r +: 16]) ==
              (i_region_base[16*r +: 16] & i_region_mask[16*r +: 16]))) begin
            sel_hit_s = 1'b1;
            sel_idx_s = IDX_W'(r);
         end else begin
            sel_hit_s = sel_hit_s;
         end
      end
      sel_mask_s = i_region_mask[16*sel_idx_s +: 16];
   end

   assign incr_s   = addr_q + 32'd2;
   assign leaves_s = (incr_s[15:0] == 16'h0000) && m_hit_q && !crossed_q &&
                     ((incr_s[31:16] & m_mask_q) != m_base_q);

`ifdef N64_REGION_DECODER_WRITE_PROTECT_EN
   assign blocked_s = i_write && m_hit_q && m_wp_q;
   assign m_wp_d    = i_address_high_op ? (sel_hit_s && i_region_wp[sel_idx_s]) : m_wp_q;
   assign unused_s  = i_n64_pi_ad[0];
`else
   assign blocked_s = 1'b0;
   assign m_wp_d    = 1'b0;
   assign unused_s  = ^{i_n64_pi_ad[0], i_write, i_region_wp, m_wp_q};
`endif

   // Next-state and output decode; high_op > low_op > access_op.
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      m_hit_d   = m_hit_q;
      m_base_d  = m_base_q;
      m_mask_d  = m_mask_q;
      m_bank_d  = m_bank_q;
      m_pref_d  = m_pref_q;
      crossed_d = crossed_q;
      bank_d    = bank_q;
      pref_d    = pref_q;
      valid_d   = valid_q;
      cross_d   = 1'b0;
      wb_d      = 1'b0;
      if (i_address_high_op) begin
         state_d        = ST_HIGH;
         addr_d[31:16]  = i_n64_pi_ad;
         m_hit_d        = sel_hit_s;
         m_mask_d       = sel_hit_s ? sel_mask_s : 16'h0000;
         m_base_d       = sel_hit_s ? (i_region_base[16*sel_idx_s +: 16] & sel_mask_s) : 16'h0000;
         m_bank_d       = sel_hit_s ? i_region_bank[BANK_W*sel_idx_s +: BANK_W] : BANK_INVALID;
         m_pref_d       = sel_hit_s && i_region_prefetch[sel_idx_s];
         valid_d        = 1'b0;
         bank_d         = BANK_INVALID;
         pref_d         = 1'b0;
      end else if (i_address_low_op) begin
         case (state_q)
            ST_HIGH: begin
               state_d      = ST_ACTIVE;
               addr_d[15:0] = {i_n64_pi_ad[15:1], 1'b0};
               crossed_d    = 1'b0;
               valid_d      = 1'b1;
               bank_d       = m_bank_q;
               pref_d       = m_pref_q;
            end
            ST_ACTIVE: addr_d[15:0] = {i_n64_pi_ad[15:1], 1'b0};
            default:   state_d = state_q;
         endcase
      end else if (i_access_op && (state_q == ST_ACTIVE)) begin
         if (blocked_s) begin
            wb_d = 1'b1;
         end else begin
            addr_d = incr_s;
            if (leaves_s) begin
               crossed_d = 1'b1;
               cross_d   = 1'b1;
               bank_d    = BANK_INVALID;
               pref_d    = 1'b0;
            end else begin
               crossed_d = crossed_q;
            end
         end
      end else begin
         state_d = state_q;
      end
   end

   // State and output registers.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q   <= ST_IDLE;
         addr_q    <= 32'h0000_0000;
         m_hit_q   <= 1'b0;
         m_base_q  <= 16'h0000;
         m_mask_q  <= 16'h0000;
         m_bank_q  <= BANK_INVALID;
         m_pref_q  <= 1'b0;
         m_wp_q    <= 1'b0;
         crossed_q <= 1'b0;
         bank_q    <= BANK_INVALID;
         pref_q    <= 1'b0;
         valid_q   <= 1'b0;
         cross_q   <= 1'b0;
         wb_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         m_hit_q   <= m_hit_d;
         m_base_q  <= m_base_d;
         m_mask_q  <= m_mask_d;
         m_bank_q  <= m_bank_d;
         m_pref_q  <= m_pref_d;
         m_wp_q    <= m_wp_d;
         crossed_q <= crossed_d;
         bank_q    <= bank_d;
         pref_q    <= pref_d;
         valid_q   <= valid_d;
         cross_q   <= cross_d;
         wb_q      <= wb_d;
      end
   end

   assign o_bank          = bank_q;
   assign o_prefetch      = pref_q;
   assign o_valid         = valid_q;
   assign o_address       = addr_q;
   assign o_crossing      = cross_q;
   assign o_write_blocked = wb_q;

endmodule

// File: tb/tb_n64_region_decoder.sv
// Directed self-checking bench for n64_region_decoder (default parameters).
module tb_n64_region_decoder;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          hi_op = 1'b0, lo_op = 1'b0, acc_op = 1'b0, wr = 1'b0;
   logic [15:0]   ad = 16'h0000;
   logic [7:0]    en = 8'h00, pf = 8'h00, wp = 8'h00;
   logic [127:0]  base = '0, mask = '0;
   logic [31:0]   bank = '0;
   logic [3:0]    o_bank;
   logic          o_prefetch, o_valid, o_crossing, o_write_blocked;
   logic [31:0]   o_address;
   int            checks = 0;
   int            errors = 0;

   always #5 clk = ~clk;

   n64_region_decoder dut (
      .i_clk(clk), .i_reset_n(rst_n),
      .i_address_high_op(hi_op), .i_address_low_op(lo_op),
      .i_n64_pi_ad(ad), .i_access_op(acc_op), .i_write(wr),
      .i_region_enable(en), .i_region_base(base), .i_region_mask(mask),
      .i_region_bank(bank), .i_region_prefetch(pf), .i_region_wp(wp),
      .o_bank(o_bank), .o_prefetch(o_prefetch), .o_valid(o_valid),
      .o_address(o_address), .o_crossing(o_crossing), .o_write_blocked(o_write_blocked)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic step(input logic h, input logic l, input logic a, input logic w, input logic [15:0] d);
      @(negedge clk);
      hi_op = h; lo_op = l; acc_op = a; wr = w; ad = d;
      @(posedge clk);
      #1;
      hi_op = 1'b0; lo_op = 1'b0; acc_op = 1'b0; wr = 1'b0;
   endtask

   task automatic set_region(input int r, input logic e, input logic [15:0] b, input logic [15:0] m,
                             input logic [3:0] bk, input logic p, input logic w);
      en[r] = e; base[16*r +: 16] = b; mask[16*r +: 16] = m;
      bank[4*r +: 4] = bk; pf[r] = p; wp[r] = w;
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_bank"}, {28'd0, o_bank}, 32'd0);
      chk({tag, "_valid"}, {31'd0, o_valid}, 32'd0);
      chk({tag, "_pref"}, {31'd0, o_prefetch}, 32'd0);
      chk({tag, "_addr"}, o_address, 32'd0);
      chk({tag, "_cross"}, {31'd0, o_crossing}, 32'd0);
      chk({tag, "_wb"}, {31'd0, o_write_blocked}, 32'd0);
   endtask

   initial begin
      #12;
      chk_idle("reset");
      rst_n = 1'b1;
      step(1'b0, 1'b1, 1'b0, 1'b0, 16'h1234);
      chk("low_in_idle_addr", o_address, 32'h0000_0000);
      chk("low_in_idle_valid", {31'd0, o_valid}, 32'd0);

      set_region(0, 1'b1, 16'h1000, 16'hFC00, 4'd1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 16'h1000);
      chk("high_valid", {31'd0, o_valid}, 32'd0);
      step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
      chk("basic_valid", {31'd0, o_valid}, 32'd1);
      chk("basic_bank", {28'd0, o_bank}, 32'd1);
      chk("basic_pref", {31'd0, o_prefetch}, 32'd1);
      chk("basic_addr", o_address, 32'h1000_0000);
      step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
      chk("incr_addr", o_address, 32'h1000_0002);
      step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0011);
      chk("reload_low_addr", o_address, 32'h1000_0010);
      set_region(0, 1'b1, 16'h1000, 16'hFC00, 4'd5, 1'b1, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
      chk("sampled_bank", {28'd0, o_bank}, 32'd1);
      chk("sampled_addr", o_address, 32'h1000_0012);

      step(1'b1, 1'b0, 1'b1, 1'b0, 16'h1000);
      chk("high_acc_addr", o_address, 32'h1000_0012);
      chk("high_acc_valid", {31'd0, o_valid}, 32'd0);
      step(1'b0, 1'b1, 1'b1, 1'b0, 16'h0020);
      chk("low_acc_addr", o_address, 32'h1000_0020);
      chk("resampled_bank", {28'd0, o_bank}, 32'd5);
      step(1'b1, 1'b0, 1'b0, 1'b0, 16'h1000);
      step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
      chk("acc_in_high_addr", o_address, 32'h1000_0020);

      set_region(0, 1'b1, 16'h0800, 16'hFF00, 4'd2, 1'b0, 1'b0);
      set_region(1, 1'b1, 16'h0800, 16'hFFFF, 4'd3, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0800);
      step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
      chk("prio_bank", {28'd0, o_bank}, 32'd2);
      chk("prio_pref", {31'd0, o_prefetch}, 32'd0);
      en[0] = 1'b0;
      step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0800);
      step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
      chk("r1_bank", {28'd0, o_bank}, 32'd3);
      chk("r1_pref", {31'd0, o_prefetch}, 32'd1);
      step(1'b1, 1'b0, 1'b0, 1'b0, 16'h5555);
      step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
      chk("nomatch_valid", {31'd0, o_valid}, 32'd1);
      chk("nomatch_bank", {28'd0, o_bank}, 32'd0);
      chk("nomatch_addr", o_address, 32'h5555_0000);

      set_region(0, 1'b1, 16'h0800, 16'hFFFF, 4'd7, 1'b1, 1'b0);
      en[1] = 1'b0;
      step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0800);
      step(1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFC);
      step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
      chk("cross1_addr", o_address, 32'h0800_FFFE);
      chk("cross1_bank", {28'd0, o_bank}, 32'd7);
      chk("cross1_pulse", {31'd0, o_crossing}, 32'd0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
      chk("cross2_addr", o_address, 32'h0801_0000);
      chk("cross2_bank", {28'd0, o_bank}, 32'd0);
      chk("cross2_pref", {31'd0, o_prefetch}, 32'd0);
      chk("cross2_pulse", {31'd0, o_crossing}, 32'd1);
      step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
      chk("cross3_addr", o_address, 32'h0801_0002);
      chk("cross3_pulse", {31'd0, o_crossing}, 32'd0);
      chk("cross3_valid", {31'd0, o_valid}, 32'd1);

      set_region(0, 1'b1, 16'h1000, 16'hFC00, 4'd1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 16'h1000);
      step(1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFE);
      step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
      chk("carry_in_region_addr", o_address, 32'h1001_0000);
      chk("carry_in_region_bank", {28'd0, o_bank}, 32'd1);
      chk("carry_in_region_pulse", {31'd0, o_crossing}, 32'd0);

      set_region(0, 1'b1, 16'hFFFF, 16'hFFFF, 4'd4, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF);
      step(1'b0, 1'b1, 1'b0, 1'b0, 16'hFFFE);
      chk("wrap_pre_bank", {28'd0, o_bank}, 32'd4);
      step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
      chk("wrap_addr", o_address, 32'h0000_0000);
      chk("wrap_pulse", {31'd0, o_crossing}, 32'd1);
      chk("wrap_bank", {28'd0, o_bank}, 32'd0);

      set_region(0, 1'b1, 16'h2000, 16'hFF00, 4'd6, 1'b0, 1'b1);
      step(1'b1, 1'b0, 1'b0, 1'b0, 16'h2000);
      step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0100);
      step(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
`ifdef N64_REGION_DECODER_WRITE_PROTECT_EN
      chk("wp_write_addr", o_address, 32'h2000_0100);
      chk("wp_write_blocked", {31'd0, o_write_blocked}, 32'd1);
      step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
      chk("wp_read_addr", o_address, 32'h2000_0102);
`else
      chk("wp_write_addr", o_address, 32'h2000_0102);
      chk("wp_write_blocked", {31'd0, o_write_blocked}, 32'd0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
      chk("wp_read_addr", o_address, 32'h2000_0104);
`endif
      chk("wp_pulse_cleared", {31'd0, o_write_blocked}, 32'd0);

      set_region(0, 1'b1, 16'h1000, 16'hFC00, 4'd1, 1'b1, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 16'h1000);
      step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0010);
      chk("pre_reset_addr", o_address, 32'h1000_0010);
      chk("pre_reset_valid", {31'd0, o_valid}, 32'd1);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk_idle("midreset");
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, 1'b0, 1'b0, 1'b0, 16'h1000);
      step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
      chk("post_reset_valid", {31'd0, o_valid}, 32'd1);
      chk("post_reset_bank", {28'd0, o_bank}, 32'd1);
      chk("post_reset_addr", o_address, 32'h1000_0000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
